mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high (`RstEnable).
REQ-003 SHALL have ports: mem_wd  in  5  destination register, from the EX/MEM register.
REQ-004 SHALL have ports: mem_wreg  in  1  write-enable, from the EX/MEM register.
REQ-005 SHALL have ports: mem_wdata  in  32  ALU result, from the EX/MEM register.
REQ-006 SHALL have ports: mem_op  in  4  access type: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9-15 treated as none.
REQ-007 SHALL have ports: mem_addr  in  32  byte address; mem_sdata  in  32  store data (rt value).
REQ-008 SHALL have ports: ram_req  out  1, ram_we  out  1, ram_addr  out  32 (word-aligned, [1:0]=0), ram_sel  out  4 byte enables, ram_wdata  out  32.
REQ-009 SHALL have ports: ram_rdata  in  32, ram_ack  in  1  data-RAM response.
REQ-010 SHALL have ports: wb_wd  out  5, wb_wreg  out  1, wb_wdata  out  32  registered write-back outputs.
REQ-011 SHALL have ports: stallreq  out  1  combinational stall to pipeline control; excp_align  out  1; bus_err  out  1.
REQ-012 SHALL have parameter TIMEOUT, default 255, max WAIT cycles before bus error.

Function
REQ-013 SHALL implement FSM IDLE, WAIT, DONE; all outputs except stallreq registered.
REQ-014 IDLE, mem_op none: next edge wb_* <= mem_wd/mem_wreg/mem_wdata; stay IDLE; stallreq 0.
REQ-015 IDLE, aligned access (LH/LHU/SH addr[0]=0; LW/SW addr[1:0]=0; bytes always): stallreq 1; next edge ram_req<=1, ram_* loaded, wb_wreg<=0, counter<=0, go WAIT.
REQ-016 IDLE, misaligned access: no request, stallreq 0, next edge wb_wreg<=0, excp_align<=1 for one cycle.
REQ-017 Byte lanes little-endian: SB sel=1<<addr[1:0], wdata={4{sdata[7:0]}}; SH sel=addr[1]?1100:0011, wdata={2{sdata[15:0]}}; SW sel=1111, wdata=sdata; loads sel same by size, ram_we=0.
REQ-018 WAIT: stallreq 1, ram_* held stable, wb_wreg 0 until ram_ack.
REQ-019 WAIT, ram_ack=1: next edge ram_req<=0; go DONE; loads: wb_wd<=mem_wd, wb_wreg<=mem_wreg, wb_wdata<=selected lane, sign-extended (LB/LH) or zero-extended (LBU/LHU); stores: wb_wreg<=0.
REQ-020 WAIT, no ack and counter=TIMEOUT-1: next edge ram_req<=0, bus_err<=1 one cycle, wb_wreg<=0, go DONE.
REQ-021 DONE: stallreq 0 for exactly one cycle (pipeline advances); next edge wb_wreg<=0, go IDLE; no re-issue of completed access.
REQ-022 Zero-wait latency: op in cycle 0, req cycles 1, ack cycle 1, wb valid cycle 2; stallreq high cycles 0-1.
REQ-023 ram_ack outside WAIT SHALL be ignored.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, counter 0, ram_req/ram_we 0, ram_addr/ram_sel/ram_wdata 0, wb_wd `NOPRegAddr, wb_wreg `WriteDisable, wb_wdata `ZeroWord, excp_align/bus_err 0.
REQ-025 While rst=1 stallreq SHALL be 0; reset in WAIT abandons the access with ram_req low next cycle.

Verification
REQ-026 Non-memory op wd=3, wreg=1, wdata=0x1234 -> next cycle wb_wd=3, wb_wreg=1, wb_wdata=0x1234, stallreq 0.
REQ-027 LB addr=0x102, ack same cycle as req, rdata=0x0080_0000 -> ram_sel=0100, stall cycles 0-1, wb_wdata=0xFFFF_FF80 in cycle 2; LBU same -> 0x0000_0080.
REQ-028 SH addr=0x206, sdata=0xABCD -> ram_we=1, ram_addr=0x204, sel=1100, wdata=0xABCD_ABCD held through 3 wait cycles, wb_wreg 0 throughout.
REQ-029 LW addr=0x101 -> no ram_req, excp_align pulse 1 cycle, stallreq 0, wb_wreg 0.
REQ-030 LW, ram_ack never asserted, TIMEOUT=4 -> ram_req 4 cycles, then bus_err pulse, DONE, IDLE.
REQ-031 rst asserted in WAIT -> next cycle ram_req 0, all outputs reset values; later ack ignored.

Source files
------------

// File: rtl/mem_access_if.sv
// Data-RAM bus between the MEM stage and the data memory.
//   master (MEM stage): drives ram_req, ram_we, ram_addr, ram_sel, ram_wdata;
//                       samples ram_rdata, ram_ack.
//   slave  (memory)   : the mirror image.
//   ram_addr is word-aligned ([1:0] = 0); ram_sel carries little-endian
//   byte enables.
interface mem_access_if;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;

    modport master (
        output ram_req, ram_we, ram_addr, ram_sel, ram_wdata,
        input  ram_rdata, ram_ack
    );

    modport slave (
        input  ram_req, ram_we, ram_addr, ram_sel, ram_wdata,
        output ram_rdata, ram_ack
    );
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: issues loads/stores to the data RAM and produces the
// registered write-back triple.
//   clk, rst            : clock, synchronous active-high reset
//   mem_wd/wreg/wdata   : write-back destination, enable, ALU result (EX/MEM)
//   mem_op              : 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH,
//                         8 SW, 9-15 none
//   mem_addr, mem_sdata : byte address and store data
//   ram                 : data-RAM bus (master side)
//   wb_wd/wreg/wdata    : registered write-back outputs
//   stallreq            : combinational stall request to pipeline control
//   excp_align          : one-cycle pulse on a misaligned access
//   bus_err             : one-cycle pulse when the RAM never acknowledges
// Parameter TIMEOUT: WAIT cycles allowed before a bus error.
module mem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   mem_wd,
    input  logic         mem_wreg,
    input  logic [31:0]  mem_wdata,
    input  logic [3:0]   mem_op,
    input  logic [31:0]  mem_addr,
    input  logic [31:0]  mem_sdata,
    mem_access_if.master ram,
    output logic [4:0]   wb_wd,
    output logic         wb_wreg,
    output logic [31:0]  wb_wdata,
    output logic         stallreq,
    output logic         excp_align,
    output logic         bus_err
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ram_req_q, ram_req_d;
    logic          ram_we_q, ram_we_d;
    logic [31:0]   ram_addr_q, ram_addr_d;
    logic [3:0]    ram_sel_q, ram_sel_d;
    logic [31:0]   ram_wdata_q, ram_wdata_d;
    logic [4:0]    wb_wd_q, wb_wd_d;
    logic          wb_wreg_q, wb_wreg_d;
    logic [31:0]   wb_wdata_q, wb_wdata_d;
    logic          excp_align_q, excp_align_d;
    logic          bus_err_q, bus_err_d;
    // Access attributes kept for lane selection when the response arrives.
    size_t         sz_q, sz_d;
    logic          sgn_q, sgn_d;
    logic          load_q, load_d;
    logic [1:0]    lo_q, lo_d;

    // Decode of the current request.
    logic          is_access, is_load, is_signed, aligned;
    size_t         sz;
    logic [3:0]    sel;
    logic [31:0]   sdata_lanes;
    // Load-data extraction from the returned word.
    logic [31:0]   rd_shift;
    logic [15:0]   rd_half;
    logic [31:0]   load_val;

    always_comb begin
        is_access = 1'b1;
        is_load   = 1'b0;
        is_signed = 1'b0;
        sz        = SZ_WORD;
        case (mem_op)
            4'd1:    begin is_load = 1'b1; is_signed = 1'b1; sz = SZ_BYTE; end
            4'd2:    begin is_load = 1'b1; sz = SZ_BYTE; end
            4'd3:    begin is_load = 1'b1; is_signed = 1'b1; sz = SZ_HALF; end
            4'd4:    begin is_load = 1'b1; sz = SZ_HALF; end
            4'd5:    begin is_load = 1'b1; sz = SZ_WORD; end
            4'd6:    sz = SZ_BYTE;
            4'd7:    sz = SZ_HALF;
            4'd8:    sz = SZ_WORD;
            default: is_access = 1'b0;
        endcase

        case (sz)
            SZ_BYTE: begin
                aligned     = 1'b1;
                sel         = 4'b0001 << mem_addr[1:0];
                sdata_lanes = {4{mem_sdata[7:0]}};
            end
            SZ_HALF: begin
                aligned     = ~mem_addr[0];
                sel         = mem_addr[1] ? 4'b1100 : 4'b0011;
                sdata_lanes = {2{mem_sdata[15:0]}};
            end
            default: begin
                aligned     = (mem_addr[1:0] == 2'b00);
                sel         = 4'b1111;
                sdata_lanes = mem_sdata;
            end
        endcase
    end

    always_comb begin
        rd_shift = ram.ram_rdata >> {lo_q, 3'b000};
        rd_half  = lo_q[1] ? ram.ram_rdata[31:16] : ram.ram_rdata[15:0];
        case (sz_q)
            SZ_BYTE: load_val = sgn_q ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                      : {24'h0, rd_shift[7:0]};
            SZ_HALF: load_val = sgn_q ? {{16{rd_half[15]}}, rd_half}
                                      : {16'h0, rd_half};
            default: load_val = ram.ram_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ram_req_d    = ram_req_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_sel_d    = ram_sel_q;
        ram_wdata_d  = ram_wdata_q;
        wb_wd_d      = wb_wd_q;
        wb_wreg_d    = wb_wreg_q;
        wb_wdata_d   = wb_wdata_q;
        excp_align_d = 1'b0;
        bus_err_d    = 1'b0;
        sz_d         = sz_q;
        sgn_d        = sgn_q;
        load_d       = load_q;
        lo_d         = lo_q;
        stallreq     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!is_access) begin
                    wb_wd_d    = mem_wd;
                    wb_wreg_d  = mem_wreg;
                    wb_wdata_d = mem_wdata;
                end else if (!aligned) begin
                    wb_wreg_d    = 1'b0;
                    excp_align_d = 1'b1;
                end else begin
                    stallreq    = 1'b1;
                    ram_req_d   = 1'b1;
                    ram_we_d    = ~is_load;
                    ram_addr_d  = {mem_addr[31:2], 2'b00};
                    ram_sel_d   = sel;
                    ram_wdata_d = is_load ? '0 : sdata_lanes;
                    wb_wreg_d   = 1'b0;
                    cnt_d       = '0;
                    sz_d        = sz;
                    sgn_d       = is_signed;
                    load_d      = is_load;
                    lo_d        = mem_addr[1:0];
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                stallreq = 1'b1;
                // An acknowledge in the final allowed cycle still completes.
                if (ram.ram_ack) begin
                    ram_req_d = 1'b0;
                    state_d   = S_DONE;
                    if (load_q) begin
                        wb_wd_d    = mem_wd;
                        wb_wreg_d  = mem_wreg;
                        wb_wdata_d = load_val;
                    end else begin
                        wb_wreg_d = 1'b0;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    ram_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    wb_wreg_d = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                // Pipeline advances this cycle; the finished op must not re-issue.
                wb_wreg_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (rst) begin
            stallreq = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ram_req_q    <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_sel_q    <= '0;
            ram_wdata_q  <= '0;
            wb_wd_q      <= '0;
            wb_wreg_q    <= 1'b0;
            wb_wdata_q   <= '0;
            excp_align_q <= 1'b0;
            bus_err_q    <= 1'b0;
            sz_q         <= SZ_BYTE;
            sgn_q        <= 1'b0;
            load_q       <= 1'b0;
            lo_q         <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ram_req_q    <= ram_req_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_sel_q    <= ram_sel_d;
            ram_wdata_q  <= ram_wdata_d;
            wb_wd_q      <= wb_wd_d;
            wb_wreg_q    <= wb_wreg_d;
            wb_wdata_q   <= wb_wdata_d;
            excp_align_q <= excp_align_d;
            bus_err_q    <= bus_err_d;
            sz_q         <= sz_d;
            sgn_q        <= sgn_d;
            load_q       <= load_d;
            lo_q         <= lo_d;
        end
    end

    assign ram.ram_req   = ram_req_q;
    assign ram.ram_we    = ram_we_q;
    assign ram.ram_addr  = ram_addr_q;
    assign ram.ram_sel   = ram_sel_q;
    assign ram.ram_wdata = ram_wdata_q;
    assign wb_wd         = wb_wd_q;
    assign wb_wreg       = wb_wreg_q;
    assign wb_wdata      = wb_wdata_q;
    assign excp_align    = excp_align_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access (TIMEOUT overridden to 4). Inputs change
// 1 time unit after each rising edge; outputs are checked after that.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_sdata;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stallreq;
    logic        excp_align;
    logic        bus_err;

    int unsigned tests = 0;
    int unsigned fails = 0;

    mem_access_if ram_if ();

    mem_access #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .mem_op    (mem_op),
        .mem_addr  (mem_addr),
        .mem_sdata (mem_sdata),
        .ram       (ram_if.master),
        .wb_wd     (wb_wd),
        .wb_wreg   (wb_wreg),
        .wb_wdata  (wb_wdata),
        .stallreq  (stallreq),
        .excp_align(excp_align),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] wd, input logic wreg);
        mem_op    = op;
        mem_addr  = addr;
        mem_sdata = sdata;
        mem_wd    = wd;
        mem_wreg  = wreg;
        mem_wdata = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        ram_if.ram_rdata = 32'h0;
        ram_if.ram_ack   = 1'b0;
        tick();
        // Aligned LW presented during reset must not stall.
        set_op(4'd5, 32'h0, 32'h0, 5'd1, 1'b1);
        #1;
        chk("rst_stall", stallreq, 0);
        tick();
        chk("rst_req",   ram_if.ram_req, 0);
        chk("rst_we",    ram_if.ram_we, 0);
        chk("rst_addr",  ram_if.ram_addr, 0);
        chk("rst_sel",   ram_if.ram_sel, 0);
        chk("rst_wdata", ram_if.ram_wdata, 0);
        chk("rst_wbwd",  wb_wd, 0);
        chk("rst_wbreg", wb_wreg, 0);
        chk("rst_wbdat", wb_wdata, 0);
        chk("rst_excp",  excp_align, 0);
        chk("rst_berr",  bus_err, 0);

        // Non-memory op passes straight to write-back.
        rst = 1'b0;
        set_op(4'd0, 32'h0, 32'h0, 5'd3, 1'b1);
        mem_wdata = 32'h1234;
        #1;
        chk("nop_stall", stallreq, 0);
        tick();
        chk("nop_wd",    wb_wd, 3);
        chk("nop_wreg",  wb_wreg, 1);
        chk("nop_wdata", wb_wdata, 32'h1234);
        chk("nop_req",   ram_if.ram_req, 0);

        // LB 0x102, zero-wait ack.
        set_op(4'd1, 32'h102, 32'h0, 5'd7, 1'b1);
        #1;
        chk("lb_stall0", stallreq, 1);
        tick();
        chk("lb_req",    ram_if.ram_req, 1);
        chk("lb_we",     ram_if.ram_we, 0);
        chk("lb_addr",   ram_if.ram_addr, 32'h100);
        chk("lb_sel",    ram_if.ram_sel, 4'b0100);
        chk("lb_wreg1",  wb_wreg, 0);
        chk("lb_stall1", stallreq, 1);
        ram_if.ram_ack   = 1'b1;
        ram_if.ram_rdata = 32'h0080_0000;
        tick();
        // ack left high in DONE: must be ignored.
        chk("lb_req2",   ram_if.ram_req, 0);
        chk("lb_stall2", stallreq, 0);
        chk("lb_wd",     wb_wd, 7);
        chk("lb_wreg2",  wb_wreg, 1);
        chk("lb_data",   wb_wdata, 32'hFFFF_FF80);
        tick();
        ram_if.ram_ack = 1'b0;
        set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        chk("lb_req3",   ram_if.ram_req, 0);
        chk("lb_wreg3",  wb_wreg, 0);
        chk("lb_stall3", stallreq, 0);
        tick();

        // LBU same address/data.
        set_op(4'd2, 32'h102, 32'h0, 5'd8, 1'b1);
        tick();
        ram_if.ram_ack = 1'b1;
        tick();
        chk("lbu_data", wb_wdata, 32'h0000_0080);
        chk("lbu_wreg", wb_wreg, 1);
        ram_if.ram_ack = 1'b0;
        tick();
        set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();

        // LH upper half, sign-extended.
        set_op(4'd3, 32'h12, 32'h0, 5'd4, 1'b1);
        tick();
        chk("lh_addr", ram_if.ram_addr, 32'h10);
        chk("lh_sel",  ram_if.ram_sel, 4'b1100);
        ram_if.ram_ack   = 1'b1;
        ram_if.ram_rdata = 32'h8001_1234;
        tick();
        chk("lh_data", wb_wdata, 32'hFFFF_8001);
        ram_if.ram_ack = 1'b0;
        tick();
        set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();

        // SH 0x206 with three wait cycles.
        set_op(4'd7, 32'h206, 32'h0000_ABCD, 5'd9, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("sh_req",   ram_if.ram_req, 1);
            chk("sh_we",    ram_if.ram_we, 1);
            chk("sh_addr",  ram_if.ram_addr, 32'h204);
            chk("sh_sel",   ram_if.ram_sel, 4'b1100);
            chk("sh_wdata", ram_if.ram_wdata, 32'hABCD_ABCD);
            chk("sh_wreg",  wb_wreg, 0);
            chk("sh_stall", stallreq, 1);
            if (i < 3) tick();
        end
        ram_if.ram_ack = 1'b1;
        tick();
        chk("sh_req_d",   ram_if.ram_req, 0);
        chk("sh_wreg_d",  wb_wreg, 0);
        chk("sh_stall_d", stallreq, 0);
        chk("sh_berr_d",  bus_err, 0);
        ram_if.ram_ack = 1'b0;
        tick();
        set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();

        // SB lane 3 and SW.
        set_op(4'd6, 32'h33, 32'h1234_5678, 5'd0, 1'b0);
        tick();
        chk("sb_addr",  ram_if.ram_addr, 32'h30);
        chk("sb_sel",   ram_if.ram_sel, 4'b1000);
        chk("sb_wdata", ram_if.ram_wdata, 32'h7878_7878);
        ram_if.ram_ack = 1'b1;
        tick();
        ram_if.ram_ack = 1'b0;
        tick();
        set_op(4'd8, 32'h20, 32'hDEAD_BEEF, 5'd0, 1'b0);
        tick();
        chk("sw_sel",   ram_if.ram_sel, 4'b1111);
        chk("sw_wdata", ram_if.ram_wdata, 32'hDEAD_BEEF);
        ram_if.ram_ack = 1'b1;
        tick();
        ram_if.ram_ack = 1'b0;
        tick();

        // Misaligned LW.
        set_op(4'd5, 32'h101, 32'h0, 5'd2, 1'b1);
        #1;
        chk("mis_stall", stallreq, 0);
        tick();
        chk("mis_req",   ram_if.ram_req, 0);
        chk("mis_excp",  excp_align, 1);
        chk("mis_wreg",  wb_wreg, 0);
        set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        chk("mis_excp2", excp_align, 0);

        // LW with no acknowledge: times out after 4 request cycles.
        set_op(4'd5, 32'h300, 32'h0, 5'd6, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_req",   ram_if.ram_req, 1);
            chk("to_berr",  bus_err, 0);
            chk("to_stall", stallreq, 1);
            tick();
        end
        chk("to_req_d",   ram_if.ram_req, 0);
        chk("to_berr_d",  bus_err, 1);
        chk("to_wreg_d",  wb_wreg, 0);
        chk("to_stall_d", stallreq, 0);
        tick();
        set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        chk("to_berr_i",  bus_err, 0);
        chk("to_stall_i", stallreq, 0);
        tick();

        // Reset while waiting abandons the access; a late ack is ignored.
        set_op(4'd5, 32'h400, 32'h0, 5'd5, 1'b1);
        tick();
        chk("rw_req", ram_if.ram_req, 1);
        rst = 1'b1;
        #1;
        chk("rw_stall", stallreq, 0);
        tick();
        chk("rw_req2",  ram_if.ram_req, 0);
        chk("rw_addr",  ram_if.ram_addr, 0);
        chk("rw_sel",   ram_if.ram_sel, 0);
        chk("rw_wd",    wb_wd, 0);
        chk("rw_wdata", wb_wdata, 0);
        rst = 1'b0;
        set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        ram_if.ram_ack   = 1'b1;
        ram_if.ram_rdata = 32'hFFFF_FFFF;
        tick();
        chk("rw_ack_req",  ram_if.ram_req, 0);
        chk("rw_ack_wreg", wb_wreg, 0);
        chk("rw_ack_dat",  wb_wdata, 0);
        ram_if.ram_ack = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
